// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 6;
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Iteration counter width for an arbitrary operand width (never zero bits).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-and-add datapath: accumulator, operand shift registers, adder and final-iteration flag.
// MULT_EARLY_TERM_EN: final iteration is flagged when the multiplier runs out of set bits.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 last
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_shift;
  logic [WIDTH-1:0]   b_shift;

  // Conditional partial-product add for the current iteration.
  always_comb begin
    acc_next = acc;
    if (b_shift[0]) begin
      acc_next = acc + a_shift;
    end else begin
      acc_next = acc;
    end
  end

  // Operand capture on load, one shift-and-add iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= {(2*WIDTH){1'b0}};
      a_shift <= {(2*WIDTH){1'b0}};
      b_shift <= {WIDTH{1'b0}};
    end else if (load) begin
      acc     <= {(2*WIDTH){1'b0}};
      a_shift <= {{WIDTH{1'b0}}, a_in};
      b_shift <= b_in;
    end else if (step) begin
      acc     <= acc_next;
      a_shift <= a_shift << 1;
      b_shift <= b_shift >> 1;
    end
  end

`ifdef MULT_EARLY_TERM_EN
  // Nothing left to add once the multiplier shifts to zero.
  assign last = (b_shift[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count;

  // Iteration counter; the run is always exactly WIDTH steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (load) begin
      count <= {CW{1'b0}};
    end else if (step) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(WIDTH - 1));
`endif

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional MULT_EARLY_TERM_EN ends the run as soon as the multiplier has no set bits left.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  state_t             state;
  state_t             next_state;
  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] acc_next;

  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a_in     (multiplicand),
    .b_in     (multiplier),
    .acc_next (acc_next),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and datapath controls; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          next_state = DONE;
        end else begin
          next_state = CALC;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered handshake outputs; product takes the final sum on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= {(2*WIDTH){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (next_state == CALC);
      done <= (next_state == DONE);
      if ((state == CALC) && (next_state == DONE)) begin
        product <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench for seq_shift_add_multiplier (WIDTH=6), honours MULT_EARLY_TERM_EN.
module tb_seq_shift_add_multiplier;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int n_cmp = 0;
  int n_err = 0;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle (relative to the accepting edge) at which done is expected.
  function automatic int lat_of(input int b);
`ifdef MULT_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    return msb + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic launch(input int a, input int b);
    multiplicand = W'(a);
    multiplier   = W'(b);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns in the IDLE cycle after DONE.
  task automatic finish_op(input string tag, input int exp, input int lat);
    for (int c = 1; c < lat; c++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(product), 32'(exp));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_product", 32'(product), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick(); tick();
    check("idle_product", 32'(product), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    launch(5, 7);
    finish_op("m5x7", 35, lat_of(7));
    tick(); tick();
    check("m5x7_hold_idle", 32'(product), 32'd35);

    launch(63, 63);
    finish_op("m63x63", 3969, lat_of(63));
    launch(0, 45);
    finish_op("m0x45", 0, lat_of(45));
    launch(45, 0);
    finish_op("m45x0", 0, lat_of(0));

    // Start re-asserted with new operands throughout the run: must be ignored.
    launch(5, 7);
    multiplicand = 6'd2; multiplier = 6'd3; start = 1'b1;
    finish_op("ignore", 35, lat_of(7));
    tick();
    start = 1'b0;
    finish_op("m2x3", 6, lat_of(3));

    // Reset in cycle 3 of a 63x63 run.
    launch(63, 63);
    tick(); tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    tick();
    check("midrst_idle", 32'(busy), 32'd0);
    launch(10, 10);
    finish_op("m10x10", 100, lat_of(10));

    launch(9, 1);
    finish_op("m9x1", 9, lat_of(1));
    launch(9, 32);
    finish_op("m9x32", 288, lat_of(32));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Sequential shift-and-add unsigned multiplier: WIDTH-bit × WIDTH-bit operands, 2*WIDTH-bit product.
- Sits directly upstream of the binary-to-BCD/7-segment stage; its product drives that stage's 12-bit Data_Input (default WIDTH=6, max product 63×63 = 3969 fits 4 digits).
- Start/busy/done handshake; product held stable between operations so the display shows the last result.

Parameters:
- WIDTH, 6, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  WIDTH  operand A, captured on accepted start
- multiplier  input  WIDTH  operand B, captured on accepted start
- product  output  2*WIDTH  result register, holds last completed product
- busy  output  1  high while an operation is in progress (LOAD/CALC)
- done  output  1  single-cycle pulse when product is updated

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; product=0, busy=0, done=0; internal accumulator, shift registers and counter cleared. Reset overrides everything, including mid-operation; the partial result is discarded and product returns to 0.
- FSM states: IDLE, CALC, DONE (enum in package).
- IDLE: busy=0, done=0. If start=1, capture A into 2*WIDTH-bit shift register (zero-extended), B into WIDTH-bit shift register, accumulator=0, counter=0 → CALC. Operands are not sampled at any other time.
- CALC: busy=1. Each cycle: if B[0]=1 then acc += A_shift; A_shift <<= 1; B_shift >>= 1; counter++. After WIDTH iterations (counter == WIDTH-1 on the iteration) → DONE.
- DONE: product <= acc (registered on entry, visible in DONE cycle), done=1, busy=0 → IDLE next cycle.
- Latency: start accepted at cycle 0 → done=1 and new product valid at cycle WIDTH+1 (cycle 7 for WIDTH=6). Fixed regardless of operand values (unless optional feature enabled).
- start while busy or in DONE: ignored, no queuing; operand changes during CALC have no effect.
- start held high continuously: new operation accepted in the IDLE cycle following each DONE; throughput one product per WIDTH+2 cycles.
- Arithmetic: unsigned, accumulator 2*WIDTH bits, never overflows (max (2^W-1)^2 < 2^(2W)).
- Zero operands: still run full WIDTH iterations; product=0.
- product changes only in DONE or on reset.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in CALC, if the shifted multiplier register becomes zero after the current iteration, go to DONE immediately (counter ignored). Latency = (index of highest set bit of B)+2 cycles from start; B=0 → DONE on the cycle after the first CALC. Product identical to non-early mode.
- Not defined: fixed WIDTH iterations as above; no comparator logic on B_shift.

Decomposition:
- Package mult_pkg: state_t enum {IDLE, CALC, DONE}; default WIDTH constant (6); counter width constant $clog2(WIDTH).
- One sub-module natural: mult_datapath (accumulator, A/B shift registers, adder, iteration counter) with load/step controls and last-iteration flag; FSM and handshake stay in seq_shift_add_multiplier.

Test Plan:
- Reset then idle: rst 2 cycles, start=0 → product=0, busy=0, done=0 held.
- 5×7, start one cycle → busy high cycles 1–6, done pulse at cycle 7, product=35 (0x023), held until next start.
- 63×63 → product=3969 (0xF81) at cycle 7; 0×45 and 45×0 → product=0, same latency.
- start re-asserted during CALC with new operands 2×3 → ignored, first result 5×7=35 unchanged; next accepted start yields 6.
- rst asserted at cycle 3 of 63×63 → next cycle product=0, busy=0, state IDLE; fresh 10×10 → 100.
- With MULT_EARLY_TERM_EN: 9×1 → done at cycle 2, product=9; 9×32 → done at cycle 7, product=288; without macro both at cycle 7.
